sha256_msg_sched: RTL and testbench



---
 rtl/sha256_pkg.sv | 18 +
 rtl/calc_w.sv | 39 +++
 rtl/sha256_msg_sched.sv | 131 +++++++++++++
 tb/tb_sha256_msg_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int DW         = 32;
  localparam int NWORDS     = 16;
  localparam int NROUNDS    = 64;
  localparam int LAST_ROUND = 63;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/calc_w.sv
// Combinational SHA-256 schedule word generator: passes the window through
// for the first 16 rounds, otherwise expands W[t] from W[t-16..t-1].
module calc_w #(
  parameter int DW     = 32,
  parameter int NWORDS = 16
) (
  input  logic [5:0]             i_Round,
  input  logic [NWORDS-1:0][DW-1:0] i_WArray,
  output logic [DW-1:0]          o_W
);

  localparam int IW = $clog2(NWORDS);

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input int n);
    rotr = (x >> n) | (x << (DW - n));
  endfunction

  function automatic logic [DW-1:0] ssig0(input logic [DW-1:0] x);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DW-1:0] ssig1(input logic [DW-1:0] x);
    ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [DW-1:0] w_expanded;

  // Window index 0 holds W[t-16], so t-2, t-7 and t-15 sit at 14, 9 and 1.
  assign w_expanded = ssig1(i_WArray[NWORDS-2]) + i_WArray[NWORDS-7]
                    + ssig0(i_WArray[NWORDS-15]) + i_WArray[NWORDS-16];

  always_comb begin
    o_W = w_expanded;
    if (i_Round < 6'(NWORDS)) begin
      o_W = i_WArray[i_Round[IW-1:0]];
    end
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads 16 words, then streams W[0..63].
// Define SHA256_SCHED_ABORT_EN to add i_Abort, which drops a partial block.
module sha256_msg_sched #(
  parameter int DW      = sha256_pkg::DW,
  parameter int NWORDS  = sha256_pkg::NWORDS,
  parameter int NROUNDS = sha256_pkg::NROUNDS
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [DW-1:0] i_MsgWord,
  input  logic          i_MsgValid,
  output logic          o_MsgReady,
  output logic [DW-1:0] o_WOut,
  output logic [5:0]    o_WRound,
  output logic          o_WValid,
  input  logic          i_WReady,
  output logic          o_BlockDone,
  output logic          o_Busy
`ifdef SHA256_SCHED_ABORT_EN
  ,
  input  logic          i_Abort
`endif
);

  import sha256_pkg::*;

  localparam int              CW         = $clog2(NWORDS);
  localparam logic [CW-1:0]   LAST_LOAD  = CW'(NWORDS - 1);
  localparam logic [5:0]      LAST_RND   = 6'(NROUNDS - 1);
  localparam logic [5:0]      FIRST_CALC = 6'(NWORDS);

  state_t                    r_state;
  state_t                    w_nextState;
  logic [CW-1:0]             r_count;
  logic [5:0]                r_round;
  logic [NWORDS-1:0][DW-1:0] r_window;
  logic [DW-1:0]             w_wCalc;
  logic                      w_abort;
  logic                      w_msgAccept;
  logic                      w_wFire;

`ifdef SHA256_SCHED_ABORT_EN
  assign w_abort = i_Abort;
`else
  assign w_abort = 1'b0;
`endif

  // A word offered together with an abort is left on the bus, not swallowed.
  assign o_MsgReady  = !i_Rst && ((r_state == IDLE) || (r_state == LOAD && !w_abort));
  assign o_WValid    = (r_state == RUN);
  assign o_BlockDone = (r_state == DONE);
  assign o_Busy      = (r_state == LOAD) || (r_state == RUN);
  assign w_msgAccept = o_MsgReady && i_MsgValid;
  assign w_wFire     = o_WValid && i_WReady;
  assign o_WOut      = w_wCalc;
  assign o_WRound    = r_round;

  calc_w #(
    .DW     (DW),
    .NWORDS (NWORDS)
  ) u_calc_w (
    .i_Round  (r_round),
    .i_WArray (r_window),
    .o_W      (w_wCalc)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_msgAccept) w_nextState = LOAD;
      end
      LOAD: begin
        if (w_abort)                                   w_nextState = IDLE;
        else if (w_msgAccept && r_count == LAST_LOAD)  w_nextState = RUN;
      end
      RUN: begin
        if (w_abort)                                   w_nextState = IDLE;
        else if (w_wFire && r_round == LAST_RND)       w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_round  <= '0;
      r_window <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_msgAccept) begin
            r_window[0] <= i_MsgWord;
            r_count     <= CW'(1);
          end
        end
        LOAD: begin
          if (w_abort) begin
            r_count <= '0;
            r_round <= '0;
          end else if (w_msgAccept) begin
            r_window[r_count] <= i_MsgWord;
            r_count           <= r_count + 1'b1;
            r_round           <= '0;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_count <= '0;
            r_round <= '0;
          end else if (w_wFire) begin
            // From round 16 on, slide so index 0 keeps tracking W[t-16].
            if (r_round >= FIRST_CALC) begin
              for (int i = 0; i < NWORDS - 1; i++) begin
                r_window[i] <= r_window[i+1];
              end
              r_window[NWORDS-1] <= w_wCalc;
            end
            r_round <= (r_round == LAST_RND) ? 6'd0 : r_round + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched; define SHA256_SCHED_ABORT_EN to test i_Abort.
module tb_sha256_msg_sched;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];
  typedef struct {
    logic [5:0]  round;
    logic [31:0] word;
    bit          abc;
  } exp_t;

  logic        i_Clk      = 1'b0;
  logic        i_Rst      = 1'b1;
  logic [31:0] i_MsgWord  = '0;
  logic        i_MsgValid = 1'b0;
  logic        i_WReady   = 1'b1;
`ifdef SHA256_SCHED_ABORT_EN
  logic        i_Abort    = 1'b0;
`endif
  logic        o_MsgReady;
  logic [31:0] o_WOut;
  logic [5:0]  o_WRound;
  logic        o_WValid;
  logic        o_BlockDone;
  logic        o_Busy;

  exp_t expQ[$];
  exp_t monE;
  int   nChecks    = 0;
  int   nFails     = 0;
  bit   expectDone = 1'b0;
  int   nStall     = 0;
  bit   stallEn    = 1'b0;
  int   stall5     = 0;
  int   stall20    = 0;

  always #5 i_Clk = ~i_Clk;

  sha256_msg_sched dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_MsgWord   (i_MsgWord),
    .i_MsgValid  (i_MsgValid),
    .o_MsgReady  (o_MsgReady),
    .o_WOut      (o_WOut),
    .o_WRound    (o_WRound),
    .o_WValid    (o_WValid),
    .i_WReady    (i_WReady),
    .o_BlockDone (o_BlockDone),
    .o_Busy      (o_Busy)
`ifdef SHA256_SCHED_ABORT_EN
    ,
    .i_Abort     (i_Abort)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule over a flat 64-entry array.
  function automatic void buildSchedule(input blk_t blk, output sched_t w);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[t];
      else        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    end
  endfunction

  // Hand-derived words of the padded "abc" block.
  task automatic checkHand(input logic [5:0] r, input logic [31:0] w);
    case (r)
      6'd0:  checkOutput("abcW0",  w, 32'h61626380);
      6'd15: checkOutput("abcW15", w, 32'h00000018);
      6'd16: checkOutput("abcW16", w, 32'h61626380);
      6'd17: checkOutput("abcW17", w, 32'h000F0000);
      6'd18: checkOutput("abcW18", w, 32'h7DA86405);
      default: ;
    endcase
  endtask

  // Monitor: compares every presented word with the scoreboard head.
  always @(negedge i_Clk) begin
    if (i_Rst) begin
      expectDone = 1'b0;
    end else begin
      checkOutput("BlockDone", 32'(o_BlockDone), 32'(expectDone));
      expectDone = 1'b0;
      if (o_WValid) begin
        checkOutput("MsgReadyInRun", 32'(o_MsgReady), 32'd0);
        checkOutput("BusyInRun", 32'(o_Busy), 32'd1);
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedWValid: got round %0d, expected no output", o_WRound);
        end else begin
          monE = expQ[0];
          checkOutput("WRound", 32'(o_WRound), 32'(monE.round));
          checkOutput("WOut", o_WOut, monE.word);
          if (!i_WReady) begin
            nStall++;
          end else begin
            if (monE.abc) checkHand(monE.round, o_WOut);
            void'(expQ.pop_front());
            if (monE.round == 6'd63) expectDone = 1'b1;
          end
        end
      end
    end
  end

  // Backpressure driver: three stall cycles at rounds 5 and 20.
  always @(posedge i_Clk) begin
    #2;
    if (stallEn && o_WValid && o_WRound == 6'd5 && stall5 > 0) begin
      i_WReady = 1'b0;
      stall5--;
    end else if (stallEn && o_WValid && o_WRound == 6'd20 && stall20 > 0) begin
      i_WReady = 1'b0;
      stall20--;
    end else begin
      i_WReady = 1'b1;
    end
  end

  task automatic sendWord(input logic [31:0] w, output int waited);
    i_MsgValid = 1'b1;
    i_MsgWord  = w;
    waited     = 0;
    while (!o_MsgReady && waited < 300) begin
      @(posedge i_Clk); #1;
      waited++;
    end
    if (!o_MsgReady) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL msgAcceptTimeout: got MsgReady=0 after %0d cycles, expected 1", waited);
      i_MsgValid = 1'b0;
    end else begin
      @(posedge i_Clk); #1;
      i_MsgValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input blk_t blk, input bit gapped, input bit isAbc, output int firstWait);
    sched_t w;
    int     waited;
    buildSchedule(blk, w);
    for (int t = 0; t < 64; t++) begin
      expQ.push_back('{round: 6'(t), word: w[t], abc: isAbc});
    end
    firstWait = 0;
    for (int i = 0; i < 16; i++) begin
      if (gapped && i > 0) begin
        i_MsgValid = 1'b0;
        @(posedge i_Clk); #1;
        checkOutput("MsgReadyInGap", 32'(o_MsgReady), 32'd1);
      end
      sendWord(blk[i], waited);
      if (i == 0) firstWait = waited;
      checkOutput("WValidAfterWord", 32'(o_WValid), (i == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (expQ.size() != 0 && cnt < 2000) begin
      @(posedge i_Clk); #1;
      cnt++;
    end
    checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
    repeat (3) @(posedge i_Clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    blk_t abcBlk;
    blk_t blkB;
    blk_t blkC;
    int   fw;
    bit   found;

    for (int i = 0; i < 16; i++) begin
      abcBlk[i] = 32'h0;
      blkB[i]   = 32'h01234567 + 32'(i) * 32'h11111111;
      blkC[i]   = 32'hDEADBEEF ^ (32'(i + 1) << i);
    end
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;

    repeat (3) @(posedge i_Clk);
    #1;
    checkOutput("rstMsgReady",  32'(o_MsgReady),  32'd0);
    checkOutput("rstWValid",    32'(o_WValid),    32'd0);
    checkOutput("rstWRound",    32'(o_WRound),    32'd0);
    checkOutput("rstWOut",      o_WOut,           32'd0);
    checkOutput("rstBlockDone", 32'(o_BlockDone), 32'd0);
    checkOutput("rstBusy",      32'(o_Busy),      32'd0);
    i_Rst = 1'b0;
    #1;
    checkOutput("idleMsgReady", 32'(o_MsgReady), 32'd1);

    applyStimulus(abcBlk, 1'b0, 1'b1, fw);
    drain();

    nStall  = 0;
    stall5  = 3;
    stall20 = 3;
    stallEn = 1'b1;
    applyStimulus(abcBlk, 1'b0, 1'b1, fw);
    drain();
    stallEn = 1'b0;
    checkOutput("stallCycles", 32'(nStall), 32'd6);

    applyStimulus(blkB, 1'b1, 1'b0, fw);
    drain();

    applyStimulus(blkC, 1'b0, 1'b0, fw);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (o_WValid && o_WRound == 6'd30) found = 1'b1;
      else begin
        @(posedge i_Clk); #1;
      end
    end
    checkOutput("reachRound30", 32'(found), 32'd1);
    i_Rst = 1'b1;
    expQ.delete();
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    #1;
    checkOutput("midRstWValid",   32'(o_WValid),   32'd0);
    checkOutput("midRstBusy",     32'(o_Busy),     32'd0);
    checkOutput("midRstMsgReady", 32'(o_MsgReady), 32'd1);
    checkOutput("midRstWRound",   32'(o_WRound),   32'd0);
    checkOutput("midRstWOut",     o_WOut,          32'd0);
    applyStimulus(abcBlk, 1'b0, 1'b1, fw);
    drain();

    applyStimulus(blkB, 1'b0, 1'b0, fw);
    applyStimulus(blkC, 1'b0, 1'b0, fw);
    checkOutput("backToBackWait", 32'(fw), 32'd65);
    drain();

`ifdef SHA256_SCHED_ABORT_EN
    for (int i = 0; i < 7; i++) sendWord(blkB[i], fw);
    i_MsgValid = 1'b1;
    i_MsgWord  = blkB[7];
    i_Abort    = 1'b1;
    @(posedge i_Clk); #1;
    i_Abort    = 1'b0;
    i_MsgValid = 1'b0;
    #1;
    checkOutput("abortBusy",     32'(o_Busy),     32'd0);
    checkOutput("abortMsgReady", 32'(o_MsgReady), 32'd1);
    checkOutput("abortWValid",   32'(o_WValid),   32'd0);
    checkOutput("abortWRound",   32'(o_WRound),   32'd0);
    repeat (5) @(posedge i_Clk);
    #1;
    checkOutput("abortStaysIdle", 32'(o_Busy), 32'd0);
    applyStimulus(blkC, 1'b0, 1'b0, fw);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
